// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor d = a - b - bin, LSB first, behind a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d, bo_q, bo_d, done_q, done_d;
  logic           ai, bi, di, br_nx;

  // Single full-subtractor cell; operands shift right so bit cnt is always at [0].
  assign ai    = a_q[0];
  assign bi    = b_q[0];
  assign di    = ai ^ bi ^ br_q;
  assign br_nx = (~ai & bi) | (~(ai ^ bi) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = {di, res_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = IDLE;
          d_d     = {di, res_q[W-1:1]};
          bo_d    = br_nx;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the last bit the cell sees the operand sign bits, and di is the result sign bit.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == SHIFT && cnt_q == CW'(W-1))
      ovf_d = (ai ^ bi) & (di ^ ai);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (W=4), hand-computed expectations.
module tb_serial_subtractor;
  logic       clk, rst_n, start, bin;
  logic [3:0] a, b;
  logic       busy, done, bo, ovf;
  logic [3:0] d;
  int         npass, ntot;

  serial_subtractor #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bo(bo), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_BUILD = 1'b1;
`else
  localparam bit OVF_BUILD = 1'b0;
`endif

  // Issues one request and waits for done; outputs are sampled on negedges.
  task automatic run_op(input logic [3:0] ai, input logic [3:0] bi_, input logic bni,
                        output logic [3:0] dd, output logic bb, output logic oo,
                        output int nbusy, output bit tmo);
    @(negedge clk);
    a = ai; b = bi_; bin = bni; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; tmo = 1'b1; dd = 'x; bb = 1'bx; oo = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        tmo = 1'b0; dd = d; bb = bo; oo = ovf;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    ntot++; if ({busy, done, d, bo, ovf} !== 8'h00)
      $display("FAIL reset: got busy=%b done=%b d=%0d bo=%b ovf=%b, want all 0", busy, done, d, bo, ovf);
    else npass++;
    rst_n = 1'b1;
    @(negedge clk);
    ntot++; if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy); else npass++;
  endtask

  task automatic test_basic;
    logic [3:0] dd; logic bb, oo; int nb; bit tmo;
    run_op(4'd9, 4'd3, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo) $display("FAIL sub_9_3_timeout: no done"); else npass++;
    ntot++; if (dd !== 4'd6 || bb !== 1'b0) $display("FAIL sub_9_3: d=%0d bo=%b want d=6 bo=0", dd, bb); else npass++;
    ntot++; if (nb !== 4) $display("FAIL sub_9_3_busy: busy cycles=%0d want 4", nb); else npass++;
    ntot++; if (busy !== 1'b0) $display("FAIL done_busy: busy=%b want 0 in done cycle", busy); else npass++;
    @(negedge clk);
    ntot++; if (done !== 1'b0 || d !== 4'd6) $display("FAIL done_pulse: done=%b d=%0d want 0,6", done, d); else npass++;
    run_op(4'd3, 4'd9, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd10 || bb !== 1'b1)
      $display("FAIL sub_3_9: d=%0d bo=%b tmo=%b want d=10 bo=1", dd, bb, tmo); else npass++;
    ntot++; if (nb !== 4) $display("FAIL sub_3_9_latency: %0d want 4", nb); else npass++;
  endtask

  task automatic test_boundary;
    logic [3:0] dd; logic bb, oo; int nb; bit tmo;
    run_op(4'd0, 4'd0, 1'b1, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd15 || bb !== 1'b1)
      $display("FAIL sub_0_0_bin: d=%0d bo=%b want d=15 bo=1", dd, bb); else npass++;
    run_op(4'd15, 4'd15, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd0 || bb !== 1'b0)
      $display("FAIL sub_15_15: d=%0d bo=%b want d=0 bo=0", dd, bb); else npass++;
    run_op(4'd5, 4'd5, 1'b1, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd15 || bb !== 1'b1)
      $display("FAIL sub_5_5_bin: d=%0d bo=%b want d=15 bo=1", dd, bb); else npass++;
  endtask

  task automatic test_busy_ignore;
    int ndone; logic [3:0] dd; logic bb;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dd = 'x; bb = 1'bx;
    for (int k = 0; k < 12; k++) begin
      if (done) begin ndone++; dd = d; bb = bo; end
      @(negedge clk);
    end
    ntot++; if (ndone !== 1) $display("FAIL ignore_done_count: %0d want 1", ndone); else npass++;
    ntot++; if (dd !== 4'd6 || bb !== 1'b0) $display("FAIL ignore_result: d=%0d bo=%b want 6,0", dd, bb); else npass++;
  endtask

  task automatic test_reset_mid;
    logic [3:0] dd; logic bb, oo; int nb; bit tmo; int ndone;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ntot++; if ({busy, done, d, bo, ovf} !== 8'h00)
      $display("FAIL reset_mid: busy=%b done=%b d=%0d bo=%b want 0", busy, done, d, bo); else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    ntot++; if (ndone !== 0) $display("FAIL reset_mid_nodone: %0d pulses want 0", ndone); else npass++;
    run_op(4'd5, 4'd2, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd3 || bb !== 1'b0)
      $display("FAIL after_reset_5_2: d=%0d bo=%b want 3,0", dd, bb); else npass++;
  endtask

  task automatic test_ovf;
    logic [3:0] dd; logic bb, oo; int nb; bit tmo;
    run_op(4'd8, 4'd1, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd7 || bb !== 1'b0)
      $display("FAIL sub_8_1: d=%0d bo=%b want 7,0", dd, bb); else npass++;
    ntot++; if (oo !== OVF_BUILD) $display("FAIL ovf_8_1: ovf=%b want %b", oo, OVF_BUILD); else npass++;
    run_op(4'd7, 4'd1, 1'b0, dd, bb, oo, nb, tmo);
    ntot++; if (tmo || dd !== 4'd6 || oo !== 1'b0)
      $display("FAIL ovf_7_1: d=%0d ovf=%b want 6,0", dd, oo); else npass++;
  endtask

  task automatic test_back_to_back;
    int t, tfirst, tsecond, ndone;
    @(negedge clk);
    a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
    tfirst = -1; tsecond = -1; ndone = 0;
    for (t = 0; t < 14; t++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (tfirst < 0) tfirst = t; else if (tsecond < 0) tsecond = t;
        ntot++; if (d !== 4'd4) $display("FAIL b2b_result: d=%0d want 4", d); else npass++;
      end
    end
    start = 1'b0;
    ntot++; if (ndone < 2 || tsecond - tfirst !== 5)
      $display("FAIL b2b_spacing: pulses=%0d gap=%0d want gap 5", ndone, tsecond - tfirst); else npass++;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    npass = 0; ntot = 0;
    test_reset;
    test_basic;
    test_boundary;
    test_busy_ignore;
    test_reset_mid;
    test_ovf;
    test_back_to_back;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
